// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bus field offsets, control-bit positions
// and the MEM-stage clear FSM state type.
package mips_pkg;

  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

  // EX/MEM bus field LSB positions
  localparam int EX_WB_LSB   = 105;
  localparam int EX_M_LSB    = 102;
  localparam int EX_TGT_LSB  = 70;
  localparam int EX_ZERO     = 69;
  localparam int EX_ALU_LSB  = 37;
  localparam int EX_SD_LSB   = 5;
  localparam int EX_RD_LSB   = 0;

  // MEM/WB bus field LSB positions
  localparam int MW_WB_LSB   = 69;
  localparam int MW_LD_LSB   = 37;
  localparam int MW_ALU_LSB  = 5;
  localparam int MW_RD_LSB   = 0;

  // control-bit positions inside the wb and m groups
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} mem_state_e;

endpackage

// File: rtl/mem_stage_data_ram.sv
// Data memory: DEPTH x 32, one shared address, synchronous write,
// asynchronous read (read returns the pre-edge word).
module data_ram #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access, branch resolution and MEM/WB register.
// After reset a clear FSM walks the memory writing zeros; the pipeline is held
// off through busy until every word has been cleared.
module mem_stage
  import mips_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXMEM_W-1:0]   exmem,
  input  logic                 stall,
  output logic [MEMWB_W-1:0]   memwb_out,
  output logic                 pc_src,
  output logic [31:0]          branch_target,
  output logic                 busy,
  output logic                 misalign_err,
  output logic [15:0]          load_cnt,
  output logic [15:0]          store_cnt
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // field extraction
  logic [1:0]  wb;
  logic [2:0]  m;
  logic        alu_zero;
  logic [31:0] alu, sdata;
  logic [4:0]  rd;

  assign wb            = exmem[EX_WB_LSB +: 2];
  assign m             = exmem[EX_M_LSB +: 3];
  assign branch_target = exmem[EX_TGT_LSB +: 32];
  assign alu_zero      = exmem[EX_ZERO];
  assign alu           = exmem[EX_ALU_LSB +: 32];
  assign sdata         = exmem[EX_SD_LSB +: 32];
  assign rd            = exmem[EX_RD_LSB +: 5];

  mem_state_e  state_q;
  logic [AW-1:0] clr_idx_q;
  logic        busy_q;

  logic [MEMWB_W-1:0] memwb_q, memwb_d;
  logic        mis_q, mis_d;
  logic [15:0] lc_q, lc_d, sc_q, sc_d;

  logic          clearing, mem_acc, misal, accept, store_ok, load_ok;
  logic [AW-1:0] idx, ram_addr;
  logic [31:0]   ram_rdata, ld_data, ram_wdata;
  logic          ram_we;
  logic [1:0]    wb_fwd;

  assign clearing = (state_q == CLEAR);
  assign idx      = alu[AW+1:2];
  assign mem_acc  = m[MEMREAD] | m[MEMWRITE];
  assign misal    = mem_acc & (alu[1:0] != 2'b00);
  assign accept   = ~clearing & ~stall;
  // a simultaneous read+write is a store; the read still sees the old word
  assign store_ok = accept & m[MEMWRITE] & ~misal;
  assign load_ok  = accept & m[MEMREAD] & ~m[MEMWRITE] & ~misal;
  assign ld_data  = (mem_acc & ~misal) ? ram_rdata : 32'd0;
  assign wb_fwd   = {wb[REGWRITE] & ~misal, wb[MEMTOREG]};

  // clear FSM owns the write port while clearing; no write while rst is high
  assign ram_we    = ~rst & (clearing | store_ok);
  assign ram_addr  = clearing ? clr_idx_q : idx;
  assign ram_wdata = clearing ? 32'd0 : sdata;

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // clear FSM: sweep every word once after reset, then run until next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == LAST_IDX) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // next-state for MEM/WB register, sticky error and counters
  always_comb begin
    memwb_d = memwb_q;
    mis_d   = mis_q;
    lc_d    = lc_q;
    sc_d    = sc_q;
    if (clearing) begin
      memwb_d = '0;
    end else if (!stall) begin
      memwb_d = {wb_fwd, ld_data, alu, rd};
      if (misal)    mis_d = 1'b1;
      if (load_ok)  lc_d  = lc_q + 16'd1;
      if (store_ok) sc_d  = sc_q + 16'd1;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_q <= '0;
      mis_q   <= 1'b0;
      lc_q    <= '0;
      sc_q    <= '0;
    end else begin
      memwb_q <= memwb_d;
      mis_q   <= mis_d;
      lc_q    <= lc_d;
      sc_q    <= sc_d;
    end
  end

  assign memwb_out    = memwb_q;
  assign busy         = busy_q;
  assign misalign_err = mis_q;
  assign load_cnt     = lc_q;
  assign store_cnt    = sc_q;
  assign pc_src       = m[BRANCH] & alu_zero & ~busy_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM stage of the 5-stage MIPS pipeline. Consumes the 107-bit EX/MEM bus. Owns the word-addressed data memory, resolves branches for the fetch stage, and registers the 71-bit MEM/WB bus. On reset, a clear FSM zeroes the data memory before the pipeline may run, so load results are always deterministic.

## Interface
Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of two, at least 4.
- AW, log2(DEPTH): word-address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high; clock clk.
- exmem  in  107  EX/MEM bus, packed as:
  - [106:105] wb, where wb[1]=regWrite and wb[0]=memToReg
  - [104:102] m, where m[2]=branch, m[1]=memRead and m[0]=memWrite
  - [101:70] branch target
  - [69] aluZero
  - [68:37] aluResult, used as the byte address
  - [36:5] store data
  - [4:0] destination register
- stall  in  1  hold MEM/WB and suppress memory write this cycle.
- memwb_out  out  71  MEM/WB bus, packed as {wb[70:69], load data[68:37], aluResult[36:5], dest reg[4:0]}.
- pc_src  out  1  branch taken (combinational).
- branch_target  out  32  exmem[101:70], passed through (combinational).
- busy  out  1  high while the clear FSM runs; the upstream stages stall on it.
- misalign_err  out  1  sticky misaligned-access flag.
- load_cnt  out  16  count of accepted loads; wraps.
- store_cnt  out  16  count of accepted stores; wraps.

## Operation
- FSM states:
  - CLEAR: rst forces CLEAR with clr_idx=0. Each cycle writes mem[clr_idx]=0 and increments clr_idx. At clr_idx==DEPTH-1 (after that write) the FSM moves to RUN. busy=1 throughout CLEAR.
  - RUN: normal operation, busy=0. The FSM stays in RUN until rst.
- Word index = aluResult[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned access: aluResult[1:0]!=0 while memRead or memWrite is set.
  - The write is suppressed.
  - Load data is 0.
  - The regWrite bit in the forwarded wb is cleared.
  - misalign_err is set and holds until rst.
  - Neither counter increments.
- memRead and memWrite both set: treated as a store. The write happens, load data returns the pre-write word, and only store_cnt increments.
- Accepted store (RUN, !stall, aligned, memWrite): mem[idx] <= store data; store_cnt++.
- Accepted load (RUN, !stall, aligned, memRead): load data = mem[idx] (the pre-edge value), registered into memwb_out; load_cnt++.
- Neither memRead nor memWrite: load data field = 0.
- pc_src = m[2] & aluZero & ~busy.

## Timing
- Reset values: memwb_out=0, misalign_err=0, load_cnt=0, store_cnt=0, busy=1 on the first cycle after rst. pc_src follows its equation, so it is 0 while busy.
- Clear takes exactly DEPTH cycles. busy falls on the edge that completes the write of mem[DEPTH-1].
- Latency: exmem sampled at edge N appears on memwb_out after edge N; the store is visible to a load sampled at edge N+1.
- During CLEAR: memwb_out <= 0 every cycle (bubble), regardless of stall.
- RUN with stall=1: memwb_out, the memory and the counters all hold.
- rst asserted mid-CLEAR or mid-RUN: clr_idx restarts at 0 and all registers reset. A store presented in the same cycle as rst is dropped.

## Structure
- Shared package mips_pkg holds:
  - EX/MEM field offsets and MEM/WB field offsets, shared with the EX/MEM and MEM/WB stages.
  - Control-bit positions: REGWRITE, MEMTOREG, BRANCH, MEMREAD, MEMWRITE.
  - FSM state enum {CLEAR, RUN}.
- One sub-module, data_ram: a single-port synchronous-write, asynchronous-read array of DEPTH x 32. The clear FSM and the store path are muxed onto its write port in mem_stage.

## Test plan
- Reset with DEPTH=256 -> busy high for 256 cycles and memwb_out==0 throughout; a load from 0x3FC afterwards returns 0.
- Store 0xDEADBEEF to 0x10, then load from 0x10 on the next cycle -> load data 0xDEADBEEF; store_cnt=1, load_cnt=1. A load from 0x410 (wraps to the same word) also returns 0xDEADBEEF.
- Store to 0x13 -> no write (a later load from 0x10 still returns 0); misalign_err=1; forwarded wb[1]=0; counters unchanged.
- branch=1 with aluZero=1 and target 0x400 -> pc_src=1 and branch_target=0x400. The same inputs during CLEAR -> pc_src=0.
- Store to 0x20 with stall=1 -> memory, memwb_out and store_cnt unchanged. Deassert stall -> the write lands and store_cnt increments.
- Assert rst at cycle 100 of CLEAR -> busy stays high for a further 256 cycles; all counters and memwb_out are 0.
